shared_line_arbiter: RTL

- Arbitrates ownership of one shared single-bit line among N requesters.
- At most one requester drives the line at any time.
- Inserts turnaround cycles between owners so two drivers never overlap.
- Models strength resolution in synthesizable form: strong driver, pull level, and highz1 (open-drain) suppression of driven 1s.

---
 rtl/shared_line_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shared_line_arbiter.sv
// ---------------------------------------------------------------------------
// shared_line_arbiter
//   Hands ownership of one shared single-bit line to at most one of N
//   requesters. Grants are round-robin, limited to MAX_HOLD cycles each, and
//   separated by TA_CYCLES idle turnaround cycles so two drivers never
//   overlap. Strength resolution is modelled in synthesizable form: the owner
//   drives strongly through oe, otherwise the line takes the pull level.
//   With HIGHZ1=1 a driven 1 is suppressed (open-drain behaviour).
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N] per-requester request (level)
//   rel      in   [N] release strobe, only the owner's bit is looked at
//   drv_val  in   [N] value each requester wants on the line
//   gnt      out  [N] one-hot grant, registered (zero when no owner)
//   oe       out  [N] strong output enable, combinational
//   line     out  resolved line value, combinational
//   line_z   out  1 when no strong driver is active, combinational
//   busy     out  1 in GRANT or TURNAROUND, registered
//   timeout  out  one-cycle pulse when MAX_HOLD revokes ownership, registered
// ---------------------------------------------------------------------------
module shared_line_arbiter #(
  parameter int N         = 4,
  parameter int MAX_HOLD  = 8,
  parameter int TA_CYCLES = 1,
  parameter bit PULL_VAL  = 1'b1,
  parameter bit HIGHZ1    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] rel,
  input  logic [N-1:0] drv_val,
  output logic [N-1:0] gnt,
  output logic [N-1:0] oe,
  output logic         line,
  output logic         line_z,
  output logic         busy,
  output logic         timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TA_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TA_LAST   = TW'(TA_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t        r_state, w_state_nx;
  logic [N-1:0]  r_gnt, w_gnt_nx;
  logic [IW-1:0] r_owner, w_owner_nx;
  logic [IW-1:0] r_ptr, w_ptr_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [TW-1:0] r_ta, w_ta_nx;
  logic          r_busy;
  logic          r_timeout, w_timeout_nx;

  logic          w_pick_found;
  logic [IW-1:0] w_pick_idx;
  logic          w_hold_last;
  logic          w_owner_done;

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_pick_found && req[(int'(r_ptr) + i) % N]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = IW'((int'(r_ptr) + i) % N);
      end
    end
  end

  assign w_hold_last  = (r_hold == HOLD_LAST);
  assign w_owner_done = rel[r_owner] | ~req[r_owner] | w_hold_last;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned; that is what keeps this block free of latches.
  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_owner_nx   = r_owner;
    w_ptr_nx     = r_ptr;
    w_hold_nx    = r_hold;
    w_ta_nx      = r_ta;
    w_timeout_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_nx           = S_GRANT;
          w_gnt_nx             = '0;
          w_gnt_nx[w_pick_idx] = 1'b1;
          w_owner_nx           = w_pick_idx;
          w_hold_nx            = '0;
        end
      end
      S_GRANT: begin
        if (w_owner_done) begin
          w_state_nx   = S_TURN;
          w_gnt_nx     = '0;
          w_ta_nx      = '0;
          w_ptr_nx     = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;
          // A voluntary release in the same cycle wins over the hold limit.
          w_timeout_nx = w_hold_last & req[r_owner] & ~rel[r_owner];
        end else begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      S_TURN: begin
        // Requests are deliberately not evaluated here.
        if (r_ta == TA_LAST) w_state_nx = S_IDLE;
        else                 w_ta_nx    = r_ta + 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_ta      <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_owner   <= w_owner_nx;
      r_ptr     <= w_ptr_nx;
      r_hold    <= w_hold_nx;
      r_ta      <= w_ta_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      r_timeout <= w_timeout_nx;
    end
  end

  // Strength resolution: only the owner may drive strongly; in open-drain
  // mode a 1 is released to the pull instead of being driven.
  assign oe      = r_gnt & ~({N{HIGHZ1}} & drv_val);
  assign line    = (|oe) ? drv_val[r_owner] : PULL_VAL;
  assign line_z  = ~|oe;
  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
